// File: rtl/sar_search_pkg.sv
`default_nettype none
// ============================================================================
// Module : sar_search_pkg
// Desc   : Shared constants, state and response encodings for the SAR search.
// Rev    : 1.0 - initial release
// ============================================================================
package sar_search_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_GT  = 2'd0,
    RSP_EQ  = 2'd1,
    RSP_LT  = 2'd2,
    RSP_BAD = 2'd3
  } rsp_t;

  localparam logic [WIDTH-1:0] MASK_INIT = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/sar_resp_decode.sv
`default_nettype none
// ============================================================================
// Module : sar_resp_decode
// Desc   : Maps the comparator gt/eq/lt flags to a response code (eq > gt > lt).
//          SAR_ERRCHK_EN adds a one-hot check that reports RSP_BAD.
// Rev    : 1.0 - initial release
// ============================================================================
module sar_resp_decode
  import sar_search_pkg::*;
(
  input  logic cmp_gt,
  input  logic cmp_eq,
  input  logic cmp_lt,
  output rsp_t rsp
);

  logic [2:0] w_flags;
  assign w_flags = {cmp_gt, cmp_eq, cmp_lt};

`ifdef SAR_ERRCHK_EN
  logic w_onehot;
  assign w_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
`endif

  always_comb begin
    // An all-zero response falls through to lt
    if (w_flags[1]) begin
      rsp = RSP_EQ;
    end else if (w_flags[2]) begin
      rsp = RSP_GT;
    end else begin
      rsp = RSP_LT;
    end
`ifdef SAR_ERRCHK_EN
    if (!w_onehot) begin
      rsp = RSP_BAD;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/sar_search_4bit.sv
`default_nettype none
// ============================================================================
// Module : sar_search_4bit
// Desc   : Successive-approximation search driving a comparator B operand.
//          Optional one-hot response checking: define SAR_ERRCHK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module sar_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       steps,
  output logic             err
);

  import sar_search_pkg::*;

  localparam logic [WIDTH-1:0] c_mask_last = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_guess, w_guess_nxt;
  logic [WIDTH-1:0] r_mask, w_mask_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [2:0]       r_steps, w_steps_nxt;
  logic [WIDTH-1:0] w_mask_sh;
  logic             w_fin;
  rsp_t             w_rsp;

  sar_resp_decode u_decode (
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .rsp    (w_rsp)
  );

  assign w_mask_sh = r_mask >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_guess  <= '0;
      r_mask   <= '0;
      r_result <= '0;
      r_steps  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_guess  <= w_guess_nxt;
      r_mask   <= w_mask_nxt;
      r_result <= w_result_nxt;
      r_steps  <= w_steps_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_guess_nxt  = r_guess;
    w_mask_nxt   = r_mask;
    w_result_nxt = r_result;
    w_steps_nxt  = r_steps;
    w_fin        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = PROBE;
          w_mask_nxt   = MASK_INIT;
          w_guess_nxt  = MASK_INIT;
          w_result_nxt = '0;
          w_steps_nxt  = '0;
        end
      end
      PROBE: begin
        w_steps_nxt = r_steps + 3'd1;
        w_fin       = (r_mask == c_mask_last);
        case (w_rsp)
          RSP_EQ: begin
            w_result_nxt = r_guess;
            w_fin        = 1'b1;
          end
          RSP_GT:  w_result_nxt = r_guess;
          RSP_LT:  w_result_nxt = r_result;
          default: begin
            w_result_nxt = '0;
            w_fin        = 1'b1;
          end
        endcase
        if (w_fin) begin
          w_state_nxt = DONE;
          w_guess_nxt = '0;
          w_mask_nxt  = '0;
        end else begin
          w_mask_nxt  = w_mask_sh;
          w_guess_nxt = w_result_nxt | w_mask_sh;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_guess_nxt = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_guess_nxt = '0;
      end
    endcase
  end

`ifdef SAR_ERRCHK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_err <= 1'b0;
    end else if ((r_state == PROBE) && (w_rsp == RSP_BAD)) begin
      r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign guess  = r_guess;
  assign result = r_result;
  assign steps  = r_steps;
  assign busy   = (r_state == PROBE);
  assign done   = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sar_search_4bit.sv
`default_nettype none
// ============================================================================
// Module : tb_sar_search_4bit
// Desc   : Self-checking bench: behavioural comparator plus a search-outcome
//          model compared every cycle; honours SAR_ERRCHK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sar_search_4bit;

`ifdef SAR_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cmp_gt, cmp_eq, cmp_lt;
  logic [3:0] guess, result;
  logic [2:0] steps;
  logic       busy, done, err;

  logic [3:0] target = 4'd0;
  logic       inj_en = 1'b0;
  logic [3:0] inj_guess = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .steps  (steps),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Comparator: target on A, guess on B; optional forced gt+eq response
  always_comb begin
    cmp_gt = (target > guess);
    cmp_eq = (target == guess);
    cmp_lt = (target < guess);
    if (inj_en && (guess == inj_guess)) begin
      cmp_gt = 1'b1;
      cmp_eq = 1'b1;
      cmp_lt = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic st_q = 1'b0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    st_q  <= start;
    rst_q <= rst_n;
  end

  // Search model: m_c counts edges since the accepted start
  logic       m_active = 1'b0;
  int         m_c = 0;
  int         p_n = 0;
  logic [3:0] p_g [4];
  logic [3:0] p_res = 4'd0;
  logic       p_err = 1'b0;
  logic [3:0] h_res = 4'd0;
  int         h_steps = 0;
  logic       h_err = 1'b0;

  initial begin
    logic [3:0] acc, g;
    logic [2:0] fl;
    logic       fin;
    logic       e_busy, e_done;
    logic [3:0] e_guess;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 1'b0; m_c = 0;
        h_res = 4'd0; h_steps = 0; h_err = 1'b0;
      end else if (!m_active) begin
        if (st_q && rst_q) begin
          acc = 4'd0; fin = 1'b0; p_n = 0; p_err = 1'b0;
          for (int j = 0; j < 4; j++) begin
            if (!fin) begin
              g = acc | (4'd8 >> j);
              p_g[j] = g;
              p_n = j + 1;
              fl = {target > g, target == g, target < g};
              if (inj_en && (g == inj_guess)) fl = 3'b110;
              if (ERRCHK && !(fl == 3'b100 || fl == 3'b010 || fl == 3'b001)) begin
                acc = 4'd0; p_err = 1'b1; fin = 1'b1;
              end else if (fl[1]) begin
                acc = g; fin = 1'b1;
              end else if (fl[2]) begin
                acc = g;
              end
            end
          end
          p_res = acc;
          m_active = 1'b1; m_c = 0;
          h_res = 4'd0; h_steps = 0; h_err = 1'b0;
        end
      end else begin
        m_c++;
        if (m_c == p_n) begin
          h_res = p_res; h_steps = p_n; h_err = p_err;
        end
        if (m_c > p_n) m_active = 1'b0;
      end
      e_busy  = m_active && (m_c < p_n);
      e_done  = m_active && (m_c == p_n);
      e_guess = e_busy ? p_g[m_c] : 4'd0;
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("guess", int'(guess), int'(e_guess));
      if (!e_busy) begin
        chk("result", int'(result), int'(h_res));
        chk("steps", int'(steps), h_steps);
        chk("err", int'(err), int'(h_err));
      end
    end
  end

  int         lat;
  logic [3:0] gs_seen [4];

  task automatic run_search(input logic [3:0] t);
    for (int i = 0; i < 4; i++) gs_seen[i] = 4'd0;
    target = t;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    gs_seen[0] = guess;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (busy && lat < 4) gs_seen[lat] = guess;
    end
    chk("done_within_bound", int'(done), 1);
    @(negedge clk);
  endtask

  initial begin
    int dcnt;
    repeat (3) @(negedge clk);
    chk("reset_guess", int'(guess), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_search(4'd15);
    chk("t15_latency", lat, 4);
    chk("t15_g1", int'(gs_seen[0]), 8);
    chk("t15_g2", int'(gs_seen[1]), 12);
    chk("t15_g3", int'(gs_seen[2]), 14);
    chk("t15_g4", int'(gs_seen[3]), 15);
    chk("t15_result", int'(result), 15);
    chk("t15_steps", int'(steps), 4);

    run_search(4'd8);
    chk("t8_latency", lat, 1);
    chk("t8_g1", int'(gs_seen[0]), 8);
    chk("t8_result", int'(result), 8);
    chk("t8_steps", int'(steps), 1);

    run_search(4'd0);
    chk("t0_latency", lat, 4);
    chk("t0_g2", int'(gs_seen[1]), 4);
    chk("t0_g3", int'(gs_seen[2]), 2);
    chk("t0_g4", int'(gs_seen[3]), 1);
    chk("t0_result", int'(result), 0);
    chk("t0_steps", int'(steps), 4);
    chk("t0_err", int'(err), 0);

    run_search(4'd3);
    run_search(4'd10);
    chk("t10_result", int'(result), 10);

    // Abort mid-search at probe 2
    target = 4'd9;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t9_probe2_guess", int'(guess), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_guess", int'(guess), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_steps", int'(steps), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // start held high: a new search every 6 cycles
    target = 4'd5;
    start  = 1'b1;
    dcnt = 0;
    repeat (18) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("held_start_done_count", dcnt, 3);
    chk("held_start_result", int'(result), 5);
    chk("held_start_steps", int'(steps), 4);
    repeat (2) @(negedge clk);

    // Forced gt+eq on the second probe
    inj_en    = 1'b1;
    inj_guess = 4'd12;
    run_search(4'd12);
    inj_en = 1'b0;
    chk("inj_latency", lat, 2);
    chk("inj_steps", int'(steps), 2);
`ifdef SAR_ERRCHK_EN
    chk("inj_err", int'(err), 1);
    chk("inj_result", int'(result), 0);
`else
    chk("inj_err", int'(err), 0);
    chk("inj_result", int'(result), 12);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
